// File: rtl/board_io_pkg.sv
// Shared types and constants for the board I/O hub.
package board_io_pkg;

    // SoC reset sequencer states
    typedef enum logic [1:0] {
        RS_HOLD,
        RS_COUNT,
        RS_RUN
    } rst_seq_e;

    // Width of the LED PWM phase counter and duty input
    localparam int PWM_W = 8;

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-FF synchroniser followed by a stable-count debouncer.
// The output follows the synchronised input only after it has disagreed with
// the output for DEBOUNCE_CYCLES consecutive cycles.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic raw_i,
    output logic deb_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;
    logic             raw_s;

    assign raw_s = sync_q[1];
    assign deb_o = deb_q;

    // Synchronise the raw pin and accept a new level once it has been stable long enough
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge, and all state uses <= so every
        // flop sees the pre-edge values of its neighbours.
        if (!srst_n_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (raw_s == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= raw_s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_io_hub.sv
// Board-level I/O front end between FPGA pins and the SoC core.
// Sequences the SoC reset from PLL lock and the reset button, debounces
// switches and buttons, raises a sticky button interrupt and drives LEDs.
// Optional feature: define BOARD_IO_HUB_PWM_EN to add led_duty_i and LED PWM dimming.
module board_io_hub
    import board_io_pkg::*;
#(
    parameter int SW_NUM          = 16,
    parameter int BTN_NUM         = 5,
    parameter int LED_NUM         = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int RST_HOLD_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               srst_n_i,
    input  logic               pll_locked_i,
    input  logic               rst_btn_n_i,
    output logic               soc_rst_o,
    input  logic [SW_NUM-1:0]  sw_i,
    input  logic [BTN_NUM-1:0] btn_i,
    output logic [SW_NUM-1:0]  sw_o,
    output logic [BTN_NUM-1:0] btn_o,
    input  logic [BTN_NUM-1:0] btn_irq_mask_i,
    output logic               irq_o,
    output logic [BTN_NUM-1:0] irq_pend_o,
    input  logic [BTN_NUM-1:0] irq_ack_i,
    input  logic [LED_NUM-1:0] led_i,
`ifdef BOARD_IO_HUB_PWM_EN
    input  logic [PWM_W-1:0]   led_duty_i,
`endif
    output logic [LED_NUM-1:0] led_o
);

    localparam int                   RST_CNT_W    = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [RST_CNT_W-1:0] RST_CNT_LAST = RST_CNT_W'(RST_HOLD_CYCLES - 1);

    logic [1:0]           lock_sync_q;
    logic [1:0]           rbtn_sync_q;
    logic                 rst_ok;
    rst_seq_e             rst_state_q, rst_state_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 soc_rst_q;

    logic [BTN_NUM-1:0]   btn_prev_q;
    logic [BTN_NUM-1:0]   btn_rise;
    logic [BTN_NUM-1:0]   pend_q;
    logic                 irq_q;
    logic [LED_NUM-1:0]   led_q;

    // ---------------- SoC reset sequencer ----------------

    // Synchronise PLL lock and the reset button into the clock domain
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            lock_sync_q <= '0;
            rbtn_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked_i};
            rbtn_sync_q <= {rbtn_sync_q[0], rst_btn_n_i};
        end
    end

    assign rst_ok = lock_sync_q[1] & rbtn_sync_q[1];

    // Sequencer state register; soc_rst_q mirrors "not in RUN" from a flop
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            rst_state_q <= RS_HOLD;
            rst_cnt_q   <= '0;
            soc_rst_q   <= 1'b1;
        end else begin
            rst_state_q <= rst_state_d;
            rst_cnt_q   <= rst_cnt_d;
            soc_rst_q   <= (rst_state_d != RS_RUN);
        end
    end

    // Next-state: lock and released button must hold RST_HOLD_CYCLES before RUN
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        rst_state_d = rst_state_q;
        rst_cnt_d   = rst_cnt_q;
        case (rst_state_q)
            RS_HOLD: begin
                rst_cnt_d = '0;
                if (rst_ok) rst_state_d = RS_COUNT;
            end
            RS_COUNT: begin
                if (!rst_ok) begin
                    rst_state_d = RS_HOLD;
                    rst_cnt_d   = '0;
                end else if (rst_cnt_q == RST_CNT_LAST) begin
                    rst_state_d = RS_RUN;
                    rst_cnt_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            RS_RUN: begin
                if (!rst_ok) rst_state_d = RS_HOLD;
            end
            default: begin
                rst_state_d = RS_HOLD;
                rst_cnt_d   = '0;
            end
        endcase
    end

    assign soc_rst_o = soc_rst_q;

    // ---------------- Switch and button debouncers ----------------

    for (genvar i = 0; i < SW_NUM; i++) begin : g_sw
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i    (clk_i),
            .srst_n_i (srst_n_i),
            .raw_i    (sw_i[i]),
            .deb_o    (sw_o[i])
        );
    end

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i    (clk_i),
            .srst_n_i (srst_n_i),
            .raw_i    (btn_i[i]),
            .deb_o    (btn_o[i])
        );
    end

    // ---------------- Button interrupt ----------------

    // Only enabled rising edges count; a masked edge is dropped, not remembered
    assign btn_rise = btn_o & ~btn_prev_q & btn_irq_mask_i;

    // Sticky pending flags, write-1-to-clear, with a new edge beating a same-cycle ack
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            btn_prev_q <= '0;
            pend_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            btn_prev_q <= btn_o;
            pend_q     <= (pend_q & ~irq_ack_i) | btn_rise;
            irq_q      <= |pend_q;
        end
    end

    assign irq_pend_o = pend_q;
    assign irq_o      = irq_q;

    // ---------------- LEDs ----------------

    // Register the core's LED request
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            led_q <= '0;
        end else begin
            led_q <= led_i;
        end
    end

`ifdef BOARD_IO_HUB_PWM_EN
    logic [PWM_W-1:0] phase_q;

    // Free-running PWM phase shared by all LEDs
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

    assign led_o = led_q & {LED_NUM{~soc_rst_q}} & {LED_NUM{phase_q < led_duty_i}};
`else
    assign led_o = led_q & {LED_NUM{~soc_rst_q}};
`endif

endmodule
